inst_resp_buf: RTL and testbench

- Sits between the IC stage and the DF/ID stage of the fetch pipeline.
- The IC stage issues instruction-memory requests. This block is the receiving end of those requests.
- It pairs each issued PC with the instruction word that returns one cycle later, and holds the pairs in a small FIFO while the pipeline stalls.
- It back-pressures the IC stage so that no returned response is ever lost.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/resp_fifo.sv | 56 +++++
 rtl/inst_resp_buf.sv | 103 ++++++++++
 tb/tb_inst_resp_buf.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-path types and constants: the {PC, instruction} entry, the
// memory response latency, and the reset/valid/zero encodings of the core.
package fetch_pkg;

  localparam int unsigned FETCH_AW  = 32;
  localparam int unsigned FETCH_DW  = 32;
  localparam int unsigned FETCH_LAT = 1;

  localparam logic        RST_EN     = 1'b1;
  localparam logic        INST_VALID = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] inst;
  } fetch_entry_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Small circular buffer of fetch entries; clear (or reset) empties it at the edge.
// Read is combinational from the head; push and pop may occur in the same cycle.
module resp_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_push,
  input  fetch_entry_t i_push_dat,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear && !i_rst) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_resp_buf.sv
// Pairs each fired PC with the instruction word returning one cycle later,
// bypassing when empty and buffering under STALL; IC_READY reserves a slot per in-flight fetch.
module inst_resp_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = FETCH_AW,
  parameter int unsigned DW    = FETCH_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] PC_I,
  input  logic          IV_I,
  output logic          IC_READY,
  input  logic [DW-1:0] INST_RDATA,
  input  logic          STALL,
  input  logic          FLUSH,
  output logic [AW-1:0] PC_O,
  output logic [DW-1:0] INST_O,
  output logic          IV_O
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic          r_pend_vld;
  logic [AW-1:0] r_pend_pc;

  logic          w_rst;
  logic          w_fire;
  logic          w_deq;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_nonempty;
  logic          w_bypass_taken;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_reserved;
  fetch_entry_t  w_arrive;
  fetch_entry_t  w_head;
  fetch_entry_t  w_present;

  assign w_rst           = (RST == RST_EN);
  assign w_fifo_nonempty = (w_count != '0);

  assign w_arrive.pc   = r_pend_pc;
  assign w_arrive.inst = INST_RDATA;

  // Every in-flight response already owns a slot, so a returning word is never dropped.
  assign w_reserved = {1'b0, w_count} + (r_pend_vld ? (CW+1)'(FETCH_LAT) : '0);
  assign IC_READY   = !w_rst && !FLUSH && (w_reserved < (CW+1)'(DEPTH));
  assign w_fire     = IV_I && IC_READY;

  always_comb begin
    w_present = w_head;
    IV_O      = ~INST_VALID;
    if (w_fifo_nonempty) begin
      w_present = w_head;
      IV_O      = INST_VALID;
    end else if (r_pend_vld) begin
      w_present = w_arrive;
      IV_O      = INST_VALID;
    end
    if (w_rst || FLUSH) begin
      IV_O = ~INST_VALID;
    end
  end

  assign PC_O   = w_rst ? AW'(ZERO_WORD) : w_present.pc;
  assign INST_O = w_rst ? DW'(ZERO_WORD) : w_present.inst;

  assign w_deq          = IV_O && !STALL;
  assign w_pop          = w_deq && w_fifo_nonempty;
  assign w_bypass_taken = w_deq && !w_fifo_nonempty;
  assign w_push         = r_pend_vld && !w_bypass_taken && !FLUSH && !w_rst;

  always_ff @(posedge CLK) begin
    if (w_rst || FLUSH) begin
      r_pend_vld <= 1'b0;
    end else begin
      r_pend_vld <= w_fire;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fire) begin
      r_pend_pc <= PC_I;
    end
  end

  resp_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk      (CLK),
    .i_rst      (w_rst),
    .i_clear    (FLUSH),
    .i_push     (w_push),
    .i_push_dat (w_arrive),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_inst_resp_buf.sv
// Directed bench for inst_resp_buf: streaming, stall absorb, ready reservation,
// flush, mid-operation reset and pointer wrap with an in-order scoreboard.
module tb_inst_resp_buf;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC_I;
  logic        IV_I;
  logic        IC_READY;
  logic [31:0] INST_RDATA;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] PC_O;
  logic [31:0] INST_O;
  logic        IV_O;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  inst_resp_buf #(.DEPTH(2), .AW(32), .DW(32)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC_I       (PC_I),
    .IV_I       (IV_I),
    .IC_READY   (IC_READY),
    .INST_RDATA (INST_RDATA),
    .STALL      (STALL),
    .FLUSH      (FLUSH),
    .PC_O       (PC_O),
    .INST_O     (INST_O),
    .IV_O       (IV_O)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slot reservation must make a push into a full buffer impossible.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      n_vec++;
      assert (!(dut.w_push && dut.w_count == 2'd2)) else begin
        n_err++;
        $error("FAIL overflow observed=%0d expected=%0d", dut.w_count, 1);
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  int          m_q[$];
  bit          m_pend;
  int          m_pidx;
  int          nfire;
  int          nout;
  int          cyc;
  bit          exp_rdy;
  bit          exp_iv;
  bit          fire;
  bit          deq;
  int          hidx;
  localparam logic [31:0] WBASE = 32'hBFC0_0200;

  initial begin
    RST = 1'b1; IV_I = 1'b1; PC_I = 32'h1234_5678; INST_RDATA = 32'hCAFE_F00D;
    STALL = 1'b0; FLUSH = 1'b0;
    #4;
    chk("rst_pc", PC_O, 32'h0);
    chk("rst_inst", INST_O, 32'h0);
    chk("rst_iv", {31'b0, IV_O}, 32'd0);
    chk("rst_rdy", {31'b0, IC_READY}, 32'd0);
    next_cycle(); next_cycle();
    RST = 1'b0; IV_I = 1'b0;
    #4;
    chk("rel_rdy", {31'b0, IC_READY}, 32'd1);
    chk("rel_iv", {31'b0, IV_O}, 32'd0);
    chk("rel_cnt", {30'b0, dut.w_count}, 32'd0);

    // Streaming
    next_cycle();
    IV_I = 1'b1; PC_I = 32'hBFC0_0000;
    #4 chk("str_rdy0", {31'b0, IC_READY}, 32'd1);
    next_cycle();
    PC_I = 32'hBFC0_0004; INST_RDATA = 32'h2408_0001;
    #4 chk("str_iv0", {31'b0, IV_O}, 32'd1);
    chk("str_pc0", PC_O, 32'hBFC0_0000);
    chk("str_in0", INST_O, 32'h2408_0001);
    chk("str_rdy1", {31'b0, IC_READY}, 32'd1);
    next_cycle();
    PC_I = 32'hBFC0_0008; INST_RDATA = 32'h2409_0002;
    #4 chk("str_iv1", {31'b0, IV_O}, 32'd1);
    chk("str_pc1", PC_O, 32'hBFC0_0004);
    chk("str_in1", INST_O, 32'h2409_0002);
    next_cycle();
    IV_I = 1'b0; INST_RDATA = 32'h240A_0003;
    #4 chk("str_iv2", {31'b0, IV_O}, 32'd1);
    chk("str_pc2", PC_O, 32'hBFC0_0008);
    chk("str_in2", INST_O, 32'h240A_0003);
    chk("str_cnt", {30'b0, dut.w_count}, 32'd0);
    next_cycle();
    #4 chk("str_idle", {31'b0, IV_O}, 32'd0);

    // Stall absorb and ready reservation
    next_cycle();
    IV_I = 1'b1; PC_I = 32'hBFC0_0000;
    next_cycle();
    PC_I = 32'hBFC0_0004; INST_RDATA = 32'hE000_0000; STALL = 1'b1;
    #4 chk("stl_rdy_a", {31'b0, IC_READY}, 32'd1);
    next_cycle();
    PC_I = 32'hBFC0_0008; INST_RDATA = 32'hE000_0001;
    #4 chk("resv_rdy", {31'b0, IC_READY}, 32'd0);
    chk("resv_cnt", {30'b0, dut.w_count}, 32'd1);
    chk("stl_pc_hold", PC_O, 32'hBFC0_0000);
    next_cycle();
    INST_RDATA = 32'h0BAD_0BAD;
    #4 chk("stl_cnt2", {30'b0, dut.w_count}, 32'd2);
    chk("stl_rdy2", {31'b0, IC_READY}, 32'd0);
    next_cycle();
    STALL = 1'b0; IV_I = 1'b0;
    #4 chk("drn_pc0", PC_O, 32'hBFC0_0000);
    chk("drn_in0", INST_O, 32'hE000_0000);
    chk("drn_rdy0", {31'b0, IC_READY}, 32'd0);
    next_cycle();
    #4 chk("drn_pc1", PC_O, 32'hBFC0_0004);
    chk("drn_in1", INST_O, 32'hE000_0001);
    chk("drn_rdy1", {31'b0, IC_READY}, 32'd1);
    next_cycle();
    #4 chk("drn_iv", {31'b0, IV_O}, 32'd0);
    chk("drn_rdy2", {31'b0, IC_READY}, 32'd1);

    // Flush with a buffered entry and a response in flight
    next_cycle();
    IV_I = 1'b1; PC_I = 32'hBFC0_0010; STALL = 1'b1;
    next_cycle();
    PC_I = 32'hBFC0_0014; INST_RDATA = 32'h1111_1111;
    next_cycle();
    FLUSH = 1'b1; PC_I = 32'hBFC0_0018; INST_RDATA = 32'hDEAD_BEEF;
    #4 chk("fl_cnt_pre", {30'b0, dut.w_count}, 32'd1);
    chk("fl_iv", {31'b0, IV_O}, 32'd0);
    chk("fl_rdy", {31'b0, IC_READY}, 32'd0);
    next_cycle();
    FLUSH = 1'b0; STALL = 1'b0; PC_I = 32'hBFC0_0100; INST_RDATA = 32'h5555_5555;
    #4 chk("fl_post_iv", {31'b0, IV_O}, 32'd0);
    chk("fl_post_cnt", {30'b0, dut.w_count}, 32'd0);
    chk("fl_post_rdy", {31'b0, IC_READY}, 32'd1);
    next_cycle();
    IV_I = 1'b0; INST_RDATA = 32'h2400_AAAA;
    #4 chk("fl_new_iv", {31'b0, IV_O}, 32'd1);
    chk("fl_new_pc", PC_O, 32'hBFC0_0100);
    chk("fl_new_in", INST_O, 32'h2400_AAAA);

    // Reset mid-operation with two entries buffered
    next_cycle();
    IV_I = 1'b1; PC_I = 32'hBFC0_0020;
    next_cycle();
    PC_I = 32'hBFC0_0024; INST_RDATA = 32'hA000_0000; STALL = 1'b1;
    next_cycle();
    IV_I = 1'b0; INST_RDATA = 32'hA000_0001;
    next_cycle();
    RST = 1'b1;
    #4 chk("mr_cnt_pre", {30'b0, dut.w_count}, 32'd2);
    chk("mr_pc", PC_O, 32'h0);
    chk("mr_in", INST_O, 32'h0);
    chk("mr_iv", {31'b0, IV_O}, 32'd0);
    chk("mr_rdy", {31'b0, IC_READY}, 32'd0);
    next_cycle();
    RST = 1'b0; STALL = 1'b0;
    #4 chk("mr_post_iv", {31'b0, IV_O}, 32'd0);
    chk("mr_post_rdy", {31'b0, IC_READY}, 32'd1);
    chk("mr_post_cnt", {30'b0, dut.w_count}, 32'd0);

    // Wrap: ten fires under alternating STALL, order checked against a scoreboard
    m_q.delete(); m_pend = 1'b0; m_pidx = 0; nfire = 0; nout = 0; cyc = 0;
    while (nout < 10 && cyc < 80) begin
      next_cycle();
      IV_I       = (nfire < 10);
      PC_I       = WBASE + 32'(4 * nfire);
      STALL      = cyc[0];
      INST_RDATA = m_pend ? (32'h3C00_0000 + 32'(m_pidx)) : 32'hBAD0_BAD0;
      #4;
      exp_rdy = ((m_q.size() + int'(m_pend)) < 2);
      exp_iv  = (m_q.size() > 0) || m_pend;
      chk("wr_rdy", {31'b0, IC_READY}, {31'b0, exp_rdy});
      chk("wr_iv", {31'b0, IV_O}, {31'b0, exp_iv});
      deq = exp_iv && !STALL;
      if (deq) begin
        hidx = (m_q.size() > 0) ? m_q[0] : m_pidx;
        chk("wr_order", 32'(hidx), 32'(nout));
        chk("wr_pc", PC_O, WBASE + 32'(4 * nout));
        chk("wr_in", INST_O, 32'h3C00_0000 + 32'(nout));
        nout++;
      end
      fire = IV_I && exp_rdy;
      if (m_q.size() > 0) begin
        if (deq) void'(m_q.pop_front());
        if (m_pend) m_q.push_back(m_pidx);
      end else if (m_pend && !deq) begin
        m_q.push_back(m_pidx);
      end
      if (fire) begin
        m_pidx = nfire;
        nfire++;
      end
      m_pend = fire;
      cyc++;
    end
    chk("wr_nout", 32'(nout), 32'd10);
    chk("wr_nfire", 32'(nfire), 32'd10);
    next_cycle();
    IV_I = 1'b0; STALL = 1'b0;
    #4 chk("wr_end_cnt", {30'b0, dut.w_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
